booth_mult_fsm: RTL and testbench

- Parametrised radix-2 Booth multiplier with its own control FSM, replacing the externally sequenced datapath (separate load_A/load_B/load_add/shift strobes).
- Accepts an operand pair over a valid/ready handshake and iterates one add/sub-and-shift step per clock.
- Presents a registered 2N-bit product over a valid/ready output handshake.
- Supports signed or unsigned operands, selected per transaction.

---
 rtl/booth_mult_fsm.sv | 123 ++++++++++++
 tb/tb_booth_mult_fsm.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_fsm.sv
// Radix-2 Booth multiplier with a built-in control FSM and valid/ready handshakes on both sides.
// Operands are widened by one bit so signed and unsigned products share the same datapath.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one add/sub-and-shift Booth step per clock, K steps total
// DONE  | product held on Y with out_valid high until out_ready
module booth_mult_fsm #(
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     A,
   input  logic [N-1:0]     B,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   Y,
   output logic [1:0]       Q_LSB,
   output logic             busy
);

   localparam int K  = N + 1;
   localparam int CW = $clog2(K + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [K-1:0]    r_m;
   logic [K-1:0]    r_hq;
   logic [K-1:0]    r_lq;
   logic            r_q1;
   logic [CW-1:0]   r_count;
   logic [2*N-1:0]  r_y;

   logic [K-1:0]    w_ext_a;
   logic [K-1:0]    w_ext_b;
   logic [K-1:0]    w_sum;
   logic [K-1:0]    w_hq_sh;
   logic [K-1:0]    w_lq_sh;
   logic            w_last;

   assign w_ext_a = signed_mode ? {A[N-1], A} : {1'b0, A};
   assign w_ext_b = signed_mode ? {B[N-1], B} : {1'b0, B};
   assign w_last  = (r_count == CW'(1));

   always_comb begin
      w_sum = r_hq;
      case ({r_lq[0], r_q1})
         2'b01:   w_sum = r_hq + r_m;
         2'b10:   w_sum = r_hq - r_m;
         default: w_sum = r_hq;
      endcase
   end

   // Arithmetic right shift of {sum, LQ, Q_1}: sum MSB replicated, sum LSB drops into LQ.
   assign w_hq_sh = {w_sum[K-1], w_sum[K-1:1]};
   assign w_lq_sh = {w_sum[0], r_lq[K-1:1]};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_CALC;
         S_CALC:  if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
      busy      = (r_state == S_CALC) || (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m     <= '0;
         r_hq    <= '0;
         r_lq    <= '0;
         r_q1    <= 1'b0;
         r_count <= '0;
         r_y     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_m     <= w_ext_a;
                  r_lq    <= w_ext_b;
                  r_hq    <= '0;
                  r_q1    <= 1'b0;
                  r_count <= CW'(K);
               end
            end
            S_CALC: begin
               r_hq    <= w_hq_sh;
               r_lq    <= w_lq_sh;
               r_q1    <= r_lq[0];
               r_count <= r_count - CW'(1);
               // Low 2N bits of the 2K-bit post-shift product are exact for N x N operands.
               if (w_last) r_y <= {w_hq_sh[N-2:0], w_lq_sh};
            end
            default: ;
         endcase
      end
   end

   assign Y     = r_y;
   assign Q_LSB = {r_lq[0], r_q1};

endmodule

// File: tb/tb_booth_mult_fsm.sv
// Directed bench for booth_mult_fsm: table of N=8 products plus hand sequences for
// backpressure, mid-operation reset, mode toggling and an N=16 instance.
module tb_booth_mult_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst8 = 1'b1, iv8 = 1'b0, sm8 = 1'b0, ordy8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        irdy8, ov8, busy8;
   logic [15:0] y8;
   logic [1:0]  q8;

   logic        rst16 = 1'b1, iv16 = 1'b0, sm16 = 1'b0, ordy16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        irdy16, ov16, busy16;
   logic [31:0] y16;
   logic [1:0]  q16;

   booth_mult_fsm #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(irdy8), .A(a8), .B(b8),
      .signed_mode(sm8), .out_valid(ov8), .out_ready(ordy8), .Y(y8), .Q_LSB(q8), .busy(busy8)
   );

   booth_mult_fsm #(.N(16)) u_dut16 (
      .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(irdy16), .A(a16), .B(b16),
      .signed_mode(sm16), .out_valid(ov16), .out_ready(ordy16), .Y(y16), .Q_LSB(q16), .busy(busy16)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        sm;
      logic [15:0] y;
   } vec_t;

   vec_t vecs[10];

   // Accept one operand pair on DUT8 and wait (bounded) for out_valid; leaves DUT in DONE.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       output logic [15:0] y, output int lat, output int rdy_hi);
      a8 = a; b8 = b; sm8 = sm; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      chk("q_lsb_after_accept", q8, {b[0], 1'b0});
      lat = 0;
      rdy_hi = 0;
      while (!ov8 && lat < 40) begin
         if (irdy8) rdy_hi++;
         tick();
         lat++;
      end
      y = y8;
   endtask

   task automatic consume8();
      ordy8 = 1'b1;
      tick();
      ordy8 = 1'b0;
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        output logic [31:0] y, output int lat);
      a16 = a; b16 = b; sm16 = sm; iv16 = 1'b1;
      tick();
      iv16 = 1'b0;
      lat = 0;
      while (!ov16 && lat < 60) begin
         tick();
         lat++;
      end
      y = y16;
      ordy16 = 1'b1;
      tick();
      ordy16 = 1'b0;
   endtask

   initial begin
      logic [15:0] y;
      logic [31:0] yw;
      int lat, rdy_hi, bad, i;

      vecs[0] = '{8'h0F, 8'h03, 1'b1, 16'h002D};
      vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      vecs[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
      vecs[5] = '{8'h07, 8'hFA, 1'b1, 16'hFFD6};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 16'h4000};
      vecs[7] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
      vecs[8] = '{8'h00, 8'h55, 1'b1, 16'h0000};
      vecs[9] = '{8'hFE, 8'h03, 1'b0, 16'h02FA};

      repeat (3) tick();
      rst8 = 1'b0; rst16 = 1'b0;

      chk("rst_in_ready", irdy8, 1);
      chk("rst_out_valid", ov8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_y", y8, 0);
      chk("rst_q_lsb", q8, 0);

      foreach (vecs[k]) begin
         run8(vecs[k].a, vecs[k].b, vecs[k].sm, y, lat, rdy_hi);
         chk($sformatf("vec%0d_y", k), y, vecs[k].y);
         chk($sformatf("vec%0d_latency", k), lat, 9);
         chk($sformatf("vec%0d_in_ready_low", k), rdy_hi, 0);
         chk($sformatf("vec%0d_busy", k), busy8, 1);
         consume8();
         chk($sformatf("vec%0d_ready_after_ack", k), {irdy8, ov8, busy8}, 3'b100);
      end

      // signed_mode and operands change mid-CALC; result must follow the accepted values.
      a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      repeat (3) tick();
      sm8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      i = 0;
      while (!ov8 && i < 40) begin tick(); i++; end
      chk("toggle_mode_y", y8, 16'hFE01);
      consume8();

      // Backpressure: hold out_ready low, poke in_valid with new operands.
      run8(8'h0F, 8'h03, 1'b1, y, lat, rdy_hi);
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         a8 = 8'h11; b8 = 8'h22; sm8 = 1'b0; iv8 = c[0];
         tick();
         if (y8 != 16'h002D || !ov8 || irdy8) bad++;
      end
      iv8 = 1'b0;
      chk("backpressure_stable", bad, 0);
      consume8();
      chk("backpressure_ack_ov", ov8, 0);
      chk("backpressure_ack_rdy", irdy8, 1);
      tick(); tick();
      chk("y_held_after_done", y8, 16'h002D);
      chk("idle_after_done", busy8, 0);

      // Reset during the 4th CALC cycle.
      a8 = 8'h7F; b8 = 8'h7F; sm8 = 1'b1; iv8 = 1'b1;
      tick();
      iv8 = 1'b0;
      repeat (3) tick();
      chk("busy_before_reset", busy8, 1);
      rst8 = 1'b1;
      tick();
      rst8 = 1'b0;
      chk("midrst_state", {irdy8, ov8, busy8}, 3'b100);
      chk("midrst_y", y8, 0);
      chk("midrst_q_lsb", q8, 0);
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (ov8 || busy8) bad++;
      end
      chk("midrst_no_result", bad, 0);
      run8(8'h07, 8'hFA, 1'b1, y, lat, rdy_hi);
      chk("post_reset_y", y, 16'hFFD6);
      chk("post_reset_latency", lat, 9);
      consume8();

      // N=16 instance.
      run16(16'h8000, 16'h0002, 1'b1, yw, lat);
      chk("n16_signed_y", yw, 32'hFFFF0000);
      chk("n16_latency", lat, 17);
      run16(16'h0000, 16'h1234, 1'b1, yw, lat);
      chk("n16_zero_y", yw, 0);
      chk("n16_idle", irdy16, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
